dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 6, data-memory word-address width (64 locations).
REQ-002 Parameter DW, default 32, data word width.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 REQ  input  2  per-requester access request; bit i belongs to requester i.
REQ-006 WE  input  2  per-requester write enable (1 write, 0 read); sampled with REQ.
REQ-007 A  input  2*AW  requester i address at bits [AW*i+AW-1 : AW*i].
REQ-008 WD  input  2*DW  requester i write data at bits [DW*i+DW-1 : DW*i].
REQ-009 GNT  output  2  one-hot acceptance pulse, one cycle.
REQ-010 RVALID  output  2  one-hot read-data-valid pulse, one cycle.
REQ-011 RD  output  DW  read data returned to the requester flagged by RVALID.
REQ-012 MEM_A  output  AW  address to the data memory.
REQ-013 MEM_WE  output  1  write enable to the data memory.
REQ-014 MEM_WD  output  DW  write data to the data memory.
REQ-015 MEM_RD  input  DW  combinational read data from the data memory (MEM_RD = mem[MEM_A]).

Function
REQ-016 FSM states IDLE, ACCESS, RESP; exactly one transaction in flight.
REQ-017 IDLE, no REQ bit set: stay IDLE, GNT=0.
REQ-018 IDLE, REQ nonzero: select winner, assert GNT[winner] combinationally that cycle, capture winner's A, WE and WD into internal registers, record owner, go to ACCESS.
REQ-019 Winner rule: if only one REQ bit is set, that requester wins; if both are set, the requester not equal to LAST wins.
REQ-020 LAST (1 bit) updates to the winner on every grant.
REQ-021 Requester may drop or change REQ/A/WE/WD after the GNT cycle; captured values are used.
REQ-022 ACCESS: MEM_A, MEM_WD = captured values; MEM_WE = captured WE; exactly one ACCESS cycle per transaction.
REQ-023 ACCESS, write: memory commits on the ACCESS-ending edge; next state IDLE; no RVALID is produced.
REQ-024 ACCESS, read: register MEM_RD into the RD register at the ACCESS-ending edge; next state RESP.
REQ-025 RESP: RVALID[owner]=1 for one cycle, RD holds the registered data; next state IDLE.
REQ-026 RD holds its last value outside RESP; RVALID=0 outside RESP.
REQ-027 GNT is asserted only in IDLE; REQ seen in ACCESS/RESP is ignored until IDLE.
REQ-028 Latency: write = 2 cycles per transaction (GNT through ACCESS); read = GNT at cycle t, RVALID at t+2; next GNT no earlier than t+3.
REQ-029 MEM_WE=0 in IDLE and RESP; MEM_A and MEM_WD hold their captured values outside ACCESS.
REQ-030 Addresses pass through unmodified at AW bits; no wrap or offset arithmetic.
REQ-031 Read after write to the same address, in either requester order, returns the newly written data, because transactions are serialized.

Reset
REQ-032 RST high at a rising edge: state=IDLE, LAST=1, owner=0, RD=0, captured A/WD/WE=0.
REQ-033 While RST is high: GNT=0, RVALID=0, MEM_WE=0 regardless of state or REQ.
REQ-034 RST asserted during ACCESS: the pending write is not committed and the pending read is dropped; no RVALID after reset.
REQ-035 First cycle after RST deasserts: state is IDLE; with both REQ bits set, requester 0 wins.

Verification
REQ-036 After reset, REQ=01, WE=01, A0=5, WD0=0xDEADBEEF -> GNT=01 the same cycle, next cycle MEM_A=5 and MEM_WE=1, afterward mem[5]=0xDEADBEEF.
REQ-037 REQ=10, WE=00, A1=5 after REQ-036 -> GNT=10 at t, RVALID=10 with RD=0xDEADBEEF at t+2.
REQ-038 REQ=11 held for 4 grants -> GNT sequence 01,10,01,10, each grant separated per the latency rules.
REQ-039 REQ asserted during ACCESS and RESP -> no GNT until IDLE; then the pending request is granted.
REQ-040 Write issued, RST pulsed in the ACCESS cycle -> MEM_WE=0 that cycle, memory location unchanged, GNT/RVALID=0, next 11 request grants requester 0.
REQ-041 Random REQ/WE/A/WD traffic, 1000 transactions vs. reference memory model -> every RD matches the model, GNT and RVALID stay one-hot or zero, and RVALID counts equal read grants.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter in front of a single-port data memory. At most one
// transaction is in flight. A request is accepted in IDLE, and its address,
// write enable and write data are registered at that point. The memory is
// driven for exactly one ACCESS cycle. A read then returns its data in a
// one-cycle RESP phase. When both requesters ask in the same cycle, the one
// that did not win last time is granted.
//
// Ports
//   CLK     : clock, all state changes on the rising edge
//   RST     : synchronous active-high reset
//   REQ     : per-requester request (bit i = requester i)
//   WE      : per-requester write enable, sampled together with REQ
//   A       : requester addresses, requester i at [AW*i +: AW]
//   WD      : requester write data, requester i at [DW*i +: DW]
//   GNT     : one-hot acceptance pulse (combinational in the accepting cycle)
//   RVALID  : one-hot read-data-valid pulse
//   RD      : registered read data, held between responses
//   MEM_A   : memory address (captured address, held outside ACCESS)
//   MEM_WE  : memory write enable, high only in a write ACCESS cycle
//   MEM_WD  : memory write data (captured data, held outside ACCESS)
//   MEM_RD  : combinational memory read data for MEM_A
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [1:0]      REQ,
  input  logic [1:0]      WE,
  input  logic [2*AW-1:0] A,
  input  logic [2*DW-1:0] WD,
  output logic [1:0]      GNT,
  output logic [1:0]      RVALID,
  output logic [DW-1:0]   RD,
  output logic [AW-1:0]   MEM_A,
  output logic            MEM_WE,
  output logic [DW-1:0]   MEM_WD,
  input  logic [DW-1:0]   MEM_RD
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q,  last_d;
  logic            owner_q, owner_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [DW-1:0]   wd_q,    wd_d;
  logic            we_q,    we_d;
  logic [DW-1:0]   rd_q,    rd_d;

  logic            winner;

  // Pick the requester to serve. A lone request always wins. On a tie, the
  // requester that was not granted last time wins, so both requesters
  // alternate under continuous contention.
  always_comb begin
    winner = 1'b0;
    case (REQ)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_q;
      default: winner = 1'b0;
    endcase
  end

  // Next-state and output logic. Reset forces the handshake and write-enable
  // outputs low whatever state the FSM was in. This keeps a reset during
  // ACCESS from committing a write or producing a late read response.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    we_d    = we_q;
    rd_d    = rd_q;
    GNT     = 2'b00;
    RVALID  = 2'b00;
    MEM_WE  = 1'b0;

    case (state_q)
      IDLE: begin
        if (REQ != 2'b00) begin
          GNT     = winner ? 2'b10 : 2'b01;
          last_d  = winner;
          owner_d = winner;
          addr_d  = winner ? A[2*AW-1:AW] : A[AW-1:0];
          wd_d    = winner ? WD[2*DW-1:DW] : WD[DW-1:0];
          we_d    = winner ? WE[1] : WE[0];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        MEM_WE = we_q;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          rd_d    = MEM_RD;
          state_d = RESP;
        end
      end
      RESP: begin
        RVALID  = owner_q ? 2'b10 : 2'b01;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (RST) begin
      GNT    = 2'b00;
      RVALID = 2'b00;
      MEM_WE = 1'b0;
    end
  end

  // State and capture registers. After reset, last points at requester 1, so
  // the first contended request goes to requester 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
    end
  end

  assign MEM_A  = addr_q;
  assign MEM_WD = wd_q;
  assign RD     = rd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter. It owns the data memory the arbiter drives. The
// stimulus side drives requests and predicts the following from a
// transaction-level model (alternating tie-break, serialized transactions,
// reference memory array):
//   - when each grant happens,
//   - which requester wins,
//   - what the memory port shows,
//   - what each read returns.
// The stimulus side pushes those predictions into queues. A separate monitor
// watches the DUT on the falling edge and pops and compares.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  typedef struct { int cyc; logic [1:0] gnt; } gntExp_t;
  typedef struct { int cyc; logic [1:0] rv; logic [DW-1:0] rd; } rdExp_t;
  typedef struct { int cyc; logic [AW-1:0] a; logic we; logic [DW-1:0] wd; } accExp_t;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [1:0]      REQ = 2'b00;
  logic [1:0]      WE  = 2'b00;
  logic [2*AW-1:0] A   = '0;
  logic [2*DW-1:0] WD  = '0;
  logic [1:0]      GNT;
  logic [1:0]      RVALID;
  logic [DW-1:0]   RD;
  logic [AW-1:0]   MEM_A;
  logic            MEM_WE;
  logic [DW-1:0]   MEM_WD;
  logic [DW-1:0]   MEM_RD;

  logic [DW-1:0]   mem [64] = '{default: '0};

  // Reference model state
  logic [DW-1:0]   refMem [64] = '{default: '0};
  logic            lastM = 1'b1;
  int              nextIdle = 0;
  int              readGrants = 0;
  int              rvalidSeen = 0;

  gntExp_t gntQ[$];
  rdExp_t  rdQ[$];
  accExp_t accQ[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ    (REQ),
    .WE     (WE),
    .A      (A),
    .WD     (WD),
    .GNT    (GNT),
    .RVALID (RVALID),
    .RD     (RD),
    .MEM_A  (MEM_A),
    .MEM_WE (MEM_WE),
    .MEM_WD (MEM_WD),
    .MEM_RD (MEM_RD)
  );

  always #5 CLK = ~CLK;

  // Cycle index: the cycle that begins at each rising edge.
  always @(posedge CLK) cyc++;

  // Data memory seen by the arbiter: combinational read, write on the edge.
  assign MEM_RD = mem[MEM_A];
  always @(posedge CLK) if (MEM_WE) mem[MEM_A] <= MEM_WD;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitCycle();
    @(posedge CLK);
    #1;
  endtask

  // Present one request pattern and hold it until the model says it is granted.
  // Once granted, the requester drops REQ and scrambles its other inputs.
  task automatic applyStimulus(input logic [1:0] reqV, input logic [1:0] weV,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] wd0, input logic [DW-1:0] wd1);
    int            g;
    logic          w;
    logic [AW-1:0] aw;
    logic [DW-1:0] dw;
    logic          wew;
    REQ = reqV;
    WE  = weV;
    A   = {a1, a0};
    WD  = {wd1, wd0};
    g   = (cyc > nextIdle) ? cyc : nextIdle;
    w   = (reqV == 2'b11) ? ~lastM : reqV[1];
    lastM = w;
    aw  = w ? a1 : a0;
    dw  = w ? wd1 : wd0;
    wew = w ? weV[1] : weV[0];
    gntQ.push_back('{g, w ? 2'b10 : 2'b01});
    accQ.push_back('{g + 1, aw, wew, dw});
    if (wew) begin
      refMem[aw] = dw;
      nextIdle = g + 2;
    end else begin
      rdQ.push_back('{g + 2, w ? 2'b10 : 2'b01, refMem[aw]});
      readGrants++;
      nextIdle = g + 3;
    end
    while (cyc <= g) waitCycle();
    REQ = 2'b00;
    WE  = 2'($urandom);
    A   = (2*AW)'($urandom);
    WD  = {$urandom, $urandom};
  endtask

  // Requester 0 starts a transaction on address 7, and reset hits its ACCESS cycle.
  task automatic resetDuringAccess(input logic weBit);
    int c;
    while (cyc < nextIdle) waitCycle();
    REQ = 2'b01;
    WE  = {1'b0, weBit};
    A   = {AW'(0), AW'(7)};
    WD  = {32'h0, 32'hA5A50000 ^ $urandom};
    c = cyc;
    gntQ.push_back('{c, 2'b01});
    accQ.push_back('{c + 1, AW'(7), 1'b0, '0});
    waitCycle();
    RST = 1'b1;
    REQ = 2'b00;
    #3;
    checkOutput("rstacc_mem_we", MEM_WE, 0);
    checkOutput("rstacc_gnt", GNT, 0);
    checkOutput("rstacc_rvalid", RVALID, 0);
    waitCycle();
    RST = 1'b0;
    lastM = 1'b1;
    nextIdle = cyc;
    checkOutput("rstacc_mem7", mem[7], refMem[7]);
    applyStimulus(2'b11, 2'($urandom), AW'($urandom), AW'($urandom), $urandom, $urandom);
  endtask

  // Monitor: compares every DUT output event against the queued predictions.
  initial begin
    gntExp_t g;
    rdExp_t  r;
    accExp_t m;
    forever begin
      @(negedge CLK);
      if (GNT != 2'b00) begin
        checkOutput("gnt_onehot", 64'($onehot(GNT)), 1);
        if (gntQ.size() == 0) checkOutput("gnt_unexpected", GNT, 0);
        else begin
          g = gntQ.pop_front();
          checkOutput("gnt_value", GNT, g.gnt);
          checkOutput("gnt_cycle", cyc, g.cyc);
        end
      end else if (gntQ.size() > 0 && gntQ[0].cyc <= cyc) begin
        g = gntQ.pop_front();
        checkOutput("gnt_missing", GNT, g.gnt);
      end

      if (RVALID != 2'b00) begin
        rvalidSeen++;
        checkOutput("rvalid_onehot", 64'($onehot(RVALID)), 1);
        if (rdQ.size() == 0) checkOutput("rvalid_unexpected", RVALID, 0);
        else begin
          r = rdQ.pop_front();
          checkOutput("rvalid_value", RVALID, r.rv);
          checkOutput("rd_data", RD, r.rd);
          checkOutput("rvalid_cycle", cyc, r.cyc);
        end
      end else if (rdQ.size() > 0 && rdQ[0].cyc <= cyc) begin
        r = rdQ.pop_front();
        checkOutput("rvalid_missing", RVALID, r.rv);
      end

      if (accQ.size() > 0 && accQ[0].cyc <= cyc) begin
        m = accQ.pop_front();
        checkOutput("access_cycle", cyc, m.cyc);
        checkOutput("mem_a", MEM_A, m.a);
        checkOutput("mem_we", MEM_WE, m.we);
        if (m.we) checkOutput("mem_wd", MEM_WD, m.wd);
      end else if (MEM_WE) begin
        checkOutput("mem_we_unexpected", MEM_WE, 0);
      end
    end
  end

  // Stimulus: reset behaviour, directed scenarios, then random traffic.
  initial begin
    logic [1:0]    rq;
    logic [AW-1:0] ra0, ra1;
    REQ = 2'b11;
    WE  = 2'b11;
    A   = (2*AW)'($urandom);
    WD  = {$urandom, $urandom};
    repeat (3) begin
      waitCycle();
      #3;
      checkOutput("rst_gnt", GNT, 0);
      checkOutput("rst_rvalid", RVALID, 0);
      checkOutput("rst_mem_we", MEM_WE, 0);
    end
    checkOutput("rst_rd", RD, 0);
    checkOutput("rst_mem_a", MEM_A, 0);
    checkOutput("rst_mem_wd", MEM_WD, 0);
    waitCycle();
    RST = 1'b0;
    REQ = 2'b00;
    nextIdle = cyc;

    // Write by requester 0, then read it back through requester 1.
    applyStimulus(2'b01, 2'b01, AW'(5), AW'(0), 32'hDEADBEEF, 32'h0);
    waitCycle();
    checkOutput("mem5_written", mem[5], 32'hDEADBEEF);
    applyStimulus(2'b10, 2'b00, AW'(0), AW'(5), 32'h0, 32'h0);

    // Sustained contention: grants alternate, and each is issued as soon as the
    // previous transaction allows.
    repeat (4) applyStimulus(2'b11, 2'($urandom), AW'($urandom), AW'($urandom), $urandom, $urandom);

    resetDuringAccess(1'b1);
    resetDuringAccess(1'b0);

    repeat (1000) begin
      repeat ($urandom_range(0, 3)) waitCycle();
      rq  = 2'($urandom_range(1, 3));
      ra0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      ra1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      applyStimulus(rq, 2'($urandom), ra0, ra1, $urandom, $urandom);
    end

    while (cyc < nextIdle + 4) waitCycle();
    checkOutput("gnt_queue_empty", gntQ.size(), 0);
    checkOutput("rd_queue_empty", rdQ.size(), 0);
    checkOutput("acc_queue_empty", accQ.size(), 0);
    checkOutput("rvalid_count", rvalidSeen, readGrants);
    for (int i = 0; i < 64; i++) checkOutput($sformatf("mem_final[%0d]", i), mem[i], refMem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
